// File: rtl/sinc3_decim_ctrl_if.sv
// sinc3_decim_ctrl_if: output word handshake bundle.
// master drives data/valid, slave returns ready.
interface sinc3_decim_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sinc3_decim_ctrl.sv
// sinc3_decim_ctrl: word_clk generator, settle discard, output capture.
// Optional macro SINC3_CTRL_OVR_CNT_EN adds the ovr_cnt saturating counter.
module sinc3_decim_ctrl #(
  parameter int WIDTH        = 16,
  parameter int SETTLE_WORDS = 4,
  parameter int CAP_DLY      = 2
) (
  input  logic             mclkin,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       dec_sel,
  input  logic [WIDTH-1:0] filt_data,
  input  logic             ovr_clr,
  output logic             word_clk,
  output logic             word_stb,
  output logic [1:0]       state,
  output logic             overrun,
`ifdef SINC3_CTRL_OVR_CNT_EN
  output logic [7:0]       ovr_cnt,
`endif
  sinc3_decim_ctrl_if.master bus
);

  localparam int SW = $clog2(SETTLE_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } st_t;

  st_t           st_q;
  st_t           st_d;
  logic [7:0]    div_cnt;
  logic [7:0]    div_nxt;
  logic [8:0]    dr_reg;
  logic [8:0]    dr_sel;
  logic [SW-1:0] settle_cnt;
  logic          start;
  logic          cap;
  logic          live;
  logic          last_settle;
  logic          ovr_evt;

  // state register
  always_ff @(posedge mclkin or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  // next-state decode
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (en) st_d = SETTLE;
      SETTLE: begin
        if (!en)              st_d = IDLE;
        else if (last_settle) st_d = RUN;
      end
      RUN:     if (!en) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // decoded controls and state output
  always_comb begin
    state       = st_q;
    dr_sel      = 9'd32 << dec_sel;
    start       = (st_q == IDLE) && en;
    cap         = (st_q != IDLE) && en &&
                  (div_cnt == 8'(CAP_DLY));
    live        = cap && (st_q == RUN);
    last_settle = cap && (st_q == SETTLE) &&
                  (settle_cnt == SW'(SETTLE_WORDS - 1));
    ovr_evt     = live && bus.out_valid && !bus.out_ready;
    if ({1'b0, div_cnt} == dr_reg - 9'd1) div_nxt = 8'd0;
    else                                  div_nxt = div_cnt + 8'd1;
  end

  // divider, word clock, settle count and output word register
  always_ff @(posedge mclkin or posedge rst) begin
    if (rst) begin
      div_cnt       <= 8'd0;
      dr_reg        <= 9'd32;
      settle_cnt    <= '0;
      word_clk      <= 1'b0;
      word_stb      <= 1'b0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        start: begin
          dr_reg     <= dr_sel;
          div_cnt    <= 8'd0;
          word_clk   <= 1'b1;
          word_stb   <= 1'b1;
          settle_cnt <= '0;
        end
        !en: begin
          div_cnt       <= 8'd0;
          word_clk      <= 1'b0;
          word_stb      <= 1'b0;
          bus.out_valid <= 1'b0;
        end
        default: begin
          div_cnt  <= div_nxt;
          word_clk <= {1'b0, div_nxt} < (dr_reg >> 1);
          word_stb <= (div_nxt == 8'd0);
          if (cap && (st_q == SETTLE))
            settle_cnt <= settle_cnt + SW'(1);
          if (live) begin
            bus.out_data  <= filt_data;
            bus.out_valid <= 1'b1;
          end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // sticky overrun: a new event beats a simultaneous clear
  always_ff @(posedge mclkin or posedge rst) begin
    if (rst)          overrun <= 1'b0;
    else if (start)   overrun <= 1'b0;
    else if (ovr_evt) overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

`ifdef SINC3_CTRL_OVR_CNT_EN
  // saturating overrun event counter
  always_ff @(posedge mclkin or posedge rst) begin
    if (rst)                  ovr_cnt <= 8'd0;
    else if (start)           ovr_cnt <= 8'd0;
    else if (ovr_evt) begin
      if (ovr_clr)            ovr_cnt <= 8'd1;
      else if (ovr_cnt != '1) ovr_cnt <= ovr_cnt + 8'd1;
    end else if (ovr_clr)     ovr_cnt <= 8'd0;
  end
`endif

endmodule

// File: doc/sinc3_decim_ctrl.md
Name: sinc3_decim_ctrl

Overview:
Sequencer for the sinc3 decimation filter. It runs in the modulator clock domain (mclkin), generates the filter's word_clk from a selectable decimation rate, and discards the words produced while the filter is settling. It then captures each settled filter word into a one-deep output register with a valid/ready handshake and reports overruns. The block sits between the sinc3 filter and the downstream sample consumer.

Parameters:
WIDTH, 16, width of filt_data and out_data.
SETTLE_WORDS, 4, captured words discarded after start (3 comb stages plus the output register).
CAP_DLY, 2, mclkin cycles after the word_clk rising edge at which filt_data is sampled; legal range 1..15.

Ports:
mclkin  in  1  modulator clock; all logic on its rising edge.
rst  in  1  asynchronous reset, active-high.
en  in  1  run enable; level-sensitive.
dec_sel  in  2  decimation rate DR: 0=32, 1=64, 2=128, 3=256.
filt_data  in  WIDTH  DATA output of the sinc3 filter.
ovr_clr  in  1  one-cycle pulse; clears overrun.
word_clk  out  1  decimated clock to the filter; 50% duty.
word_stb  out  1  one-cycle pulse coincident with each word_clk rising edge.
out_data  out  WIDTH  captured filter word.
out_valid  out  1  out_data holds an unconsumed word.
out_ready  in  1  consumer accepts the word when out_valid and out_ready are both high.
state  out  2  0=IDLE, 1=SETTLE, 2=RUN.
overrun  out  1  sticky flag: a word was overwritten before it was consumed.

Behaviour:
- Reset values: word_clk=0, word_stb=0, out_data=0, out_valid=0, state=IDLE, overrun=0. Internal: div_cnt=0, settle_cnt=0, dr_reg=32.
- IDLE:
  - div_cnt held at 0, word_clk=0.
  - en=1 at edge k: dr_reg<=DR(dec_sel), div_cnt<=0, word_clk<=1, word_stb<=1, settle_cnt<=0, overrun<=0; state<=SETTLE.
- SETTLE and RUN:
  - div_cnt counts 0..dr_reg-1 and wraps to 0.
  - word_clk=1 while div_cnt<dr_reg/2, otherwise 0.
  - word_stb=1 exactly in the cycle in which div_cnt==0.
- Capture event: the cycle in which div_cnt==CAP_DLY.
  - SETTLE: increment settle_cnt. On the capture that makes settle_cnt==SETTLE_WORDS, state<=RUN; that word is still discarded.
  - RUN: out_data<=filt_data, out_valid<=1. If out_valid=1 and out_ready=0 in the same cycle, overrun<=1 and the old word is lost (newest wins).
- Handshake:
  - out_valid falls in the cycle after out_valid & out_ready, unless a capture occurs in the same cycle; then out_valid stays 1 with the new data and no overrun is flagged.
  - out_data is stable while out_valid=1 and no capture occurs.
- en=0 in SETTLE or RUN: next cycle state=IDLE, div_cnt=0, word_clk=0, word_stb=0, out_valid=0. out_data and overrun are kept.
- dec_sel is sampled only on the IDLE->SETTLE transition; changes while running are ignored until the next restart.
- ovr_clr: clears overrun. If ovr_clr and an overrun event occur in the same cycle, the event wins (overrun=1).
- Latency: first out_valid is registered at edge k+CAP_DLY+1+SETTLE_WORDS*DR, i.e. k+131 for DR=32 with default parameters. Subsequent words follow every DR cycles.
- rst asserted mid-operation returns every register to its reset value immediately.

Optional Feature:
SINC3_CTRL_OVR_CNT_EN:
- Defined: adds output ovr_cnt [7:0], a saturating count of overrun events (holds at 255). It is cleared by ovr_clr (an event in the same cycle gives 1), by the IDLE->SETTLE transition, and by rst.
- Undefined: the port and its counter are absent; the overrun flag is unchanged.

Test Plan:
1. rst, then en=1 with dec_sel=0 at edge k, filt_data=16'h1234, out_ready=1 -> word_stb pulses every 32 cycles; word_clk is high 16 cycles and low 16 cycles; state=RUN after the 4th capture; first out_valid at k+131 with out_data=16'h1234; out_valid is high one cycle per word.
2. dec_sel=3, out_ready=1 -> word_stb period 256, word_clk high 128 cycles; changing dec_sel to 0 mid-run leaves the period at 256.
3. RUN with out_ready=0 across two captures (data A then B) -> out_data=B, overrun=1; ovr_clr pulse -> overrun=0. With SINC3_CTRL_OVR_CNT_EN, 300 missed words -> ovr_cnt=255.
4. out_ready asserted in the exact capture cycle while out_valid=1 -> out_valid stays 1 with the new word and overrun stays 0.
5. en dropped mid-SETTLE and mid-RUN -> next cycle state=IDLE, word_clk=0, out_valid=0; re-enable discards 4 words again.
6. rst pulsed while word_clk=1 and out_valid=1 -> all outputs immediately return to 0 and state=IDLE, with no clock edge needed.
